// File: rtl/gate_pkg.sv
// Shared types for the gate ALU pipeline: operation encoding and result flag bundle.
package gate_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_NOT_A  = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

  typedef struct packed {
    logic zero;
    logic all_ones;
    logic parity;
  } flags_t;

  localparam int unsigned FLAGS_W = $bits(flags_t);

endpackage

// File: rtl/gate_pipe_reg.sv
// One valid/ready pipeline stage: payload register plus valid bit, loads on upstream handshake.
module gate_pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready_c,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  logic load_c;

  // Accept when empty or when the current beat leaves this same cycle.
  assign up_ready_c = !dn_valid || dn_ready;
  assign load_c     = up_valid && up_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (load_c) begin
      dn_valid <= 1'b1;
      dn_data  <= up_data;
    end else if (dn_ready) begin
      dn_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/gate_alu_pipe.sv
// Two-stage valid/ready bitwise logic unit with result flags and a saturating result counter.
module gate_alu_pipe
  import gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_all_ones,
  output logic             y_parity,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned S1_W = 2 * WIDTH + OP_W;
  localparam int unsigned S2_W = WIDTH + FLAGS_W;

  logic              s1_valid;
  logic [S1_W-1:0]   s1_q;
  logic              s2_ready_c;
  logic [WIDTH-1:0]  s1_a;
  logic [WIDTH-1:0]  s1_b;
  op_e               s1_op;
  logic [WIDTH-1:0]  y_c;
  flags_t            flags_c;
  logic [S2_W-1:0]   s2_q;
  flags_t            s2_flags;

  gate_pipe_reg #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .up_valid  (in_valid),
    .up_ready_c(in_ready),
    .up_data   ({a, b, op}),
    .dn_valid  (s1_valid),
    .dn_ready  (s2_ready_c),
    .dn_data   (s1_q)
  );

  assign s1_a  = s1_q[S1_W-1 -: WIDTH];
  assign s1_b  = s1_q[OP_W +: WIDTH];
  assign s1_op = op_e'(s1_q[OP_W-1:0]);

  // Operation decode on the stage-1 operands.
  always_comb begin
    y_c = '0;
    unique case (s1_op)
      OP_AND:    y_c = s1_a & s1_b;
      OP_OR:     y_c = s1_a | s1_b;
      OP_XOR:    y_c = s1_a ^ s1_b;
      OP_NAND:   y_c = ~(s1_a & s1_b);
      OP_NOR:    y_c = ~(s1_a | s1_b);
      OP_XNOR:   y_c = ~(s1_a ^ s1_b);
      OP_NOT_A:  y_c = ~s1_a;
      OP_PASS_A: y_c = s1_a;
    endcase
  end

  // Flags derive from the same-cycle result so they always match the registered y.
  always_comb begin
    flags_c          = '0;
    flags_c.zero     = ~|y_c;
    flags_c.all_ones = &y_c;
    flags_c.parity   = ^y_c;
  end

  gate_pipe_reg #(.W(S2_W)) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .up_valid  (s1_valid),
    .up_ready_c(s2_ready_c),
    .up_data   ({y_c, flags_c}),
    .dn_valid  (out_valid),
    .dn_ready  (out_ready),
    .dn_data   (s2_q)
  );

  assign {y, s2_flags} = s2_q;
  assign y_zero        = s2_flags.zero;
  assign y_all_ones    = s2_flags.all_ones;
  assign y_parity      = s2_flags.parity;

  // Completed-result counter; clear beats a coincident handshake, saturates at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (cnt_clr) begin
      op_count <= '0;
    end else if (out_valid && out_ready && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gate_alu_pipe.sv
// Scoreboard bench for gate_alu_pipe: directed beats push expectations, a monitor pops and compares.
module tb_gate_alu_pipe;
  import gate_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [OP_W-1:0]  op = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] y;
  logic             y_zero;
  logic             y_all_ones;
  logic             y_parity;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] op_count;

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic       o;
    logic       p;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic stall_prev = 1'b0;
  exp_t held;

  gate_alu_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_zero    (y_zero),
    .y_all_ones(y_all_ones),
    .y_parity  (y_parity),
    .cnt_clr   (cnt_clr),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] vop,
                      input logic [7:0] ey, input logic ez, input logic eo, input logic ep);
    int n = 0;
    a = va; b = vb; op = vop; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    else sb.push_back({ey, ez, eo, ep});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compare each accepted output with the queue head, and check holds during stalls.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        got = {y, y_zero, y_all_ones, y_parity};
        if (stall_prev) chk("stall_hold", 32'({out_valid, got}), 32'({1'b1, held}));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_output", 32'(got), 32'hFFFF_FFFF);
          else begin
            e = sb.pop_front();
            chk("result", 32'(got), 32'(e));
          end
        end
        stall_prev = out_valid && !out_ready;
        held = got;
      end
    end
  end

  initial begin
    logic [7:0] stream_exp [8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hA5};
    logic [7:0] va;
    longint t0;
    longint t1;
    int n;

    // Reset values
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_flags", 32'({y_zero, y_all_ones, y_parity}), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single AND beat and its two-edge latency
    send(8'hF0, 8'h3C, 3'(OP_AND), 8'h30, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("latency_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 chk("count_first", 32'(op_count), 32'd1);

    // Flag corner cases
    send(8'h00, 8'h00, 3'(OP_NOR), 8'hFF, 1'b0, 1'b1, 1'b0);
    send(8'hA5, 8'hA5, 3'(OP_XOR), 8'h00, 1'b1, 1'b0, 1'b0);
    wait_drain();
    @(posedge clk);
    #1 chk("count_three", 32'(op_count), 32'd3);

    // All eight ops back to back
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    chk("count_cleared", 32'(op_count), 32'd0);
    t0 = longint'($time);
    for (int i = 0; i < 8; i++) send(8'hA5, 8'h0F, 3'(i), stream_exp[i], 1'b0, 1'b0, 1'b0);
    t1 = longint'($time);
    chk("stream_cycles", 32'((t1 - t0) / 10), 32'd8);
    wait_drain();
    @(posedge clk);
    #1 chk("count_stream", 32'(op_count), 32'd8);

    // Backpressure: two beats buffer, the third is refused until the output drains
    out_ready = 1'b0;
    send(8'h01, 8'h00, 3'(OP_XOR), 8'h01, 1'b0, 1'b0, 1'b1);
    send(8'h80, 8'h07, 3'(OP_OR), 8'h87, 1'b0, 1'b0, 1'b0);
    fork
      send(8'hFF, 8'hFE, 3'(OP_NAND), 8'h01, 1'b0, 1'b0, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("third_blocked", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    @(posedge clk);
    #1 chk("count_stall", 32'(op_count), 32'd11);

    // Mid-flight asynchronous reset discards both buffered beats
    out_ready = 1'b0;
    send(8'h12, 8'h34, 3'(OP_OR), 8'h36, 1'b0, 1'b0, 1'b0);
    send(8'h56, 8'h78, 3'(OP_AND), 8'h50, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    stall_prev = 1'b0;
    sb.delete();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_op_count", 32'(op_count), 32'd0);
    chk("midrst_y", 32'(y), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale_output", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(8'h0F, 8'h0E, 3'(OP_XNOR), 8'hFE, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("post_rst_not_yet", 32'(out_valid), 32'd0);
    wait_drain();
    @(posedge clk);
    #1 chk("count_post_rst", 32'(op_count), 32'd1);

    // Saturation: 20 more handshakes must stick at 15
    for (int i = 0; i < 20; i++) begin
      va = 8'(i * 37);
      send(va, 8'h00, 3'(OP_PASS_A), va, va == 8'h00, va == 8'hFF, 1'($countones(va) % 2));
    end
    wait_drain();
    @(posedge clk);
    #1 chk("count_saturated", 32'(op_count), 32'd15);

    // Clear coincident with an output handshake wins
    out_ready = 1'b0;
    send(8'h0F, 8'h03, 3'(OP_AND), 8'h03, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("clr_wait_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    chk("clr_beats_handshake", 32'(op_count), 32'd0);
    chk("clr_beat_consumed", 32'(out_valid), 32'd0);

    wait_drain();
    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_alu_pipe.md
Name: gate_alu_pipe

Overview:
Parametrised, pipelined successor to the single-bit two-input AND gate. It applies one of eight bitwise logic operations, selected per transaction, to two WIDTH-bit operands. It also produces reduction flags on the result and counts completed results. Two registered stages sit between valid/ready handshakes, so the block drops into any streaming datapath in the gate-library test environment.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 16, width of completed-result counter (>=2)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/op beat valid
in_ready  output  1  block can accept beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  operation select (gate_pkg::op_e)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
y  output  WIDTH  result
y_zero  output  1  y == 0
y_all_ones  output  1  y == all ones
y_parity  output  1  XOR-reduction of y
cnt_clr  input  1  synchronous clear of op_count
op_count  output  CNT_W  number of completed output handshakes, saturating

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, y=0, y_zero=0, y_all_ones=0, y_parity=0, op_count=0. Takes effect immediately, mid-transaction included; in-flight beats are discarded. Nothing stale appears after release.
- Ops: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT_A (~a, b ignored), 7 PASS_A (a). All codes are defined; there is no illegal-op case.
- Stage 1 registers a, b, op on input handshake (in_valid && in_ready).
- Stage 2 computes the op from stage-1 registers. It registers y and the three flags, computed from the computed y in the same cycle. out_valid = s2_valid.
- Advance rules:
  - s2_load = s1_valid && (!s2_valid || out_ready)
  - in_ready = !s1_valid || s2_load (combinational path from out_ready is permitted)
- s1_valid update: set on input handshake; else cleared when s2_load.
- s2_valid update: set on s2_load; else cleared on output handshake (out_valid && out_ready).
- Latency: result is valid 2 cycles after the accepting edge with no stalls. Throughput is 1 beat/cycle with out_ready held high.
- Stall: while out_valid && !out_ready, y and all flags hold stable, and out_valid never deasserts. Up to 2 beats are buffered; a 3rd sees in_ready=0.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- op_count increments by 1 on each output handshake and saturates at 2^CNT_W-1 (no wrap).
- cnt_clr=1 forces op_count=0 next edge. cnt_clr wins over a simultaneous handshake.
- WIDTH=1: y_zero = ~y, y_all_ones = y, y_parity = y.

Decomposition:
- Package gate_pkg:
  - typedef enum logic [2:0] op_e {OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_NOT_A, OP_PASS_A}
  - localparam OP_W = 3
  - function gate_eval(op, a, b), parametrised by width via a parametrised class or a let construct; otherwise implement it inside the module.
- One sub-module, gate_pipe_reg: parametrised-width payload register with valid/ready and async active-low reset, instantiated for stages 1 and 2. The top holds op decode, flag logic and the counter.

Test Plan:
- WIDTH=8, op=AND, a=8'hF0, b=8'h3C, out_ready=1 -> 2 cycles after accept: y=8'h30, y_zero=0, y_all_ones=0, y_parity=0, op_count=1.
- op=NOR, a=8'h00, b=8'h00 -> y=8'hFF, y_all_ones=1, y_parity=0. Then op=XOR, a=8'hA5, b=8'hA5 -> y=8'h00, y_zero=1.
- Stream ops 0..7 back-to-back with a=8'hA5, b=8'h0F, out_ready=1 -> one result per cycle in order: 05, AF, AA, FA, 50, 55, 5A, A5; op_count=8.
- out_ready=0, drive 3 consecutive beats -> first 2 accepted, in_ready=0 on 3rd, y held stable. Raise out_ready -> all 3 emerge in order, no loss.
- rst_n pulled low for half a cycle with both stages valid -> out_valid=0 and op_count=0 immediately. After release, no output until a new beat is sent and then its 2-cycle latency elapses.
- CNT_W=4, 20 handshakes -> op_count=15 (saturated). Assert cnt_clr in the same cycle as a handshake -> op_count=0 next cycle.
